dmem_arbiter: RTL and testbench

- Shares the single-port data memory (Dmemory32) between two requesters: the CPU data path (via MemOrIO) and a UART program/data loader.
- Sequences each access as a fixed multi-cycle transaction: arbitrate, issue, wait, acknowledge.
- Produces a stall for the CPU while its access is pending.
- Sits between MemOrIO/loader and Dmemory32 in the CPU top.

---
 rtl/dmem_arbiter_if.sv | 50 +++++
 rtl/dmem_arbiter.sv | 105 ++++++++++
 tb/tb_dmem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle of the CPU, loader and memory-side signals around the data-memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 32
) ();
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_lock;
  logic              ld_ack;
  logic [DATA_W-1:0] ld_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ld_req, ld_we, ld_addr, ld_wdata, ld_lock,
    input  mem_rdata,
    output cpu_ack, cpu_rdata, cpu_stall,
    output ld_ack, ld_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ld_req, ld_we, ld_addr, ld_wdata, ld_lock,
    output mem_rdata,
    input  cpu_ack, cpu_rdata, cpu_stall,
    input  ld_ack, ld_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU and the UART loader.
// Every access runs IDLE -> ISSUE -> WAIT (RD_LAT cycles) -> DONE with registered outputs.
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input logic           clock,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  localparam int unsigned CntW = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e            state_q;
  logic              last_gnt_q;  // 1 = loader
  logic              gnt_q;       // 1 = loader
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rd_q;
  logic [CntW-1:0]   cnt_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic              cpu_ack_q;
  logic              ld_ack_q;

  logic cpu_elig;
  logic ld_elig;
  logic pick_ld;

  assign cpu_elig = bus.cpu_req & ~bus.ld_lock;
  assign ld_elig  = bus.ld_req;
  // On a tie the loader wins only if the CPU was served last.
  assign pick_ld  = ld_elig & (~cpu_elig | ~last_gnt_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      last_gnt_q <= 1'b1;
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      cpu_ack_q  <= 1'b0;
      ld_ack_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cpu_elig || ld_elig) begin
            gnt_q      <= pick_ld;
            last_gnt_q <= pick_ld;
            we_q       <= pick_ld ? bus.ld_we    : bus.cpu_we;
            addr_q     <= pick_ld ? bus.ld_addr  : bus.cpu_addr;
            wdata_q    <= pick_ld ? bus.ld_wdata : bus.cpu_wdata;
            mem_en_q   <= 1'b1;
            mem_we_q   <= pick_ld ? bus.ld_we    : bus.cpu_we;
            state_q    <= StIssue;
          end
        end
        StIssue: begin
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          cnt_q    <= CntW'(RD_LAT);
          state_q  <= StWait;
        end
        StWait: begin
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            if (!we_q) begin
              rd_q <= bus.mem_rdata;
            end
            cpu_ack_q <= ~gnt_q;
            ld_ack_q  <= gnt_q;
            state_q   <= StDone;
          end
        end
        StDone: begin
          cpu_ack_q <= 1'b0;
          ld_ack_q  <= 1'b0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.ld_ack    = ld_ack_q;
  assign bus.cpu_rdata = rd_q;
  assign bus.ld_rdata  = rd_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.cpu_stall = bus.cpu_req & ~cpu_ack_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: one RD_LAT=1 and one RD_LAT=4 instance, each with a memory model,
// checked against a transaction-level reference model (grant order, ack cycle, memory image).
module tb_dmem_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Shared stimulus; sel picks which instance sees the requests and is observed.
  bit          sel = 1'b0;
  logic        creq = 0, cwe = 0, lreq = 0, lwe = 0, lock = 0;
  logic [13:0] caddr = '0, laddr = '0;
  logic [31:0] cwdata = '0, lwdata = '0;
  logic        clr = 1'b1, pl_en = 1'b1;

  dmem_arbiter_if ifa ();
  dmem_arbiter_if ifb ();

  dmem_arbiter #(.ADDR_W(14), .DATA_W(32), .RD_LAT(1)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (ifa)
  );

  dmem_arbiter #(.ADDR_W(14), .DATA_W(32), .RD_LAT(4)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (ifb)
  );

  assign ifa.cpu_req   = !sel && creq;
  assign ifa.ld_req    = !sel && lreq;
  assign ifb.cpu_req   = sel && creq;
  assign ifb.ld_req    = sel && lreq;
  assign ifa.cpu_we    = cwe;
  assign ifb.cpu_we    = cwe;
  assign ifa.cpu_addr  = caddr;
  assign ifb.cpu_addr  = caddr;
  assign ifa.cpu_wdata = cwdata;
  assign ifb.cpu_wdata = cwdata;
  assign ifa.ld_we     = lwe;
  assign ifb.ld_we     = lwe;
  assign ifa.ld_addr   = laddr;
  assign ifb.ld_addr   = laddr;
  assign ifa.ld_wdata  = lwdata;
  assign ifb.ld_wdata  = lwdata;
  assign ifa.ld_lock   = lock;
  assign ifb.ld_lock   = lock;

  // Memory models: read data appears RD_LAT cycles after the strobe, X otherwise.
  logic [31:0] mem_a [1024];
  logic [31:0] mem_b [1024];
  logic [31:0] pipe_a;
  logic [31:0] pipe_b [4];

  always @(posedge clock) begin
    if (clr) begin
      for (int i = 0; i < 1024; i++) mem_a[i] <= '0;
    end else if (ifa.mem_en && ifa.mem_we) begin
      mem_a[ifa.mem_addr[9:0]] <= ifa.mem_wdata;
    end
    pipe_a <= ifa.mem_en ? mem_a[ifa.mem_addr[9:0]] : 'x;
  end
  assign ifa.mem_rdata = pipe_a;

  always @(posedge clock) begin
    if (clr) begin
      for (int i = 0; i < 1024; i++) mem_b[i] <= '0;
    end else if (ifb.mem_en && ifb.mem_we) begin
      mem_b[ifb.mem_addr[9:0]] <= ifb.mem_wdata;
    end
    if (pl_en) mem_b[10'h155] <= 32'h1234_5678;
    pipe_b[0] <= ifb.mem_en ? mem_b[ifb.mem_addr[9:0]] : 'x;
    for (int i = 1; i < 4; i++) pipe_b[i] <= pipe_b[i-1];
  end
  assign ifb.mem_rdata = pipe_b[3];

  logic        o_busy, o_mem_en, o_mem_we, o_cpu_ack, o_ld_ack, o_cpu_stall;
  logic [13:0] o_mem_addr;
  logic [31:0] o_mem_wdata, o_cpu_rdata, o_ld_rdata;
  assign o_busy      = sel ? ifb.busy      : ifa.busy;
  assign o_mem_en    = sel ? ifb.mem_en    : ifa.mem_en;
  assign o_mem_we    = sel ? ifb.mem_we    : ifa.mem_we;
  assign o_mem_addr  = sel ? ifb.mem_addr  : ifa.mem_addr;
  assign o_mem_wdata = sel ? ifb.mem_wdata : ifa.mem_wdata;
  assign o_cpu_ack   = sel ? ifb.cpu_ack   : ifa.cpu_ack;
  assign o_ld_ack    = sel ? ifb.ld_ack    : ifa.ld_ack;
  assign o_cpu_stall = sel ? ifb.cpu_stall : ifa.cpu_stall;
  assign o_cpu_rdata = sel ? ifb.cpu_rdata : ifa.cpu_rdata;
  assign o_ld_rdata  = sel ? ifb.ld_rdata  : ifa.ld_rdata;

  // Reference model state per instance: last served requester (1 = loader), last read word.
  bit          m_last [2];
  logic [31:0] m_rd   [2];
  logic [31:0] m_mem  [int];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},   o_busy, 0);
    chk({tag, "_mem_en"}, o_mem_en, 0);
    chk({tag, "_mem_we"}, o_mem_we, 0);
    chk({tag, "_addr"},   o_mem_addr, 0);
    chk({tag, "_wdata"},  o_mem_wdata, 0);
    chk({tag, "_cack"},   o_cpu_ack, 0);
    chk({tag, "_lack"},   o_ld_ack, 0);
    chk({tag, "_crd"},    o_cpu_rdata, 0);
    chk({tag, "_lrd"},    o_ld_rdata, 0);
    chk({tag, "_stall"},  o_cpu_stall, creq);
  endtask

  task automatic model_reset();
    m_last[0] = 1'b1;
    m_last[1] = 1'b1;
    m_rd[0]   = '0;
    m_rd[1]   = '0;
  endtask

  // Runs one transaction from an IDLE cycle using the currently driven requests.
  task automatic txn(input bit wiggle);
    int          lat;
    int          key;
    bit          g;
    logic        we;
    logic [13:0] a;
    logic [31:0] wd;
    lat = sel ? 4 : 1;
    if ((creq && !lock) && lreq) g = !m_last[sel];
    else                         g = lreq;
    m_last[sel] = g;
    we  = g ? lwe    : cwe;
    a   = g ? laddr  : caddr;
    wd  = g ? lwdata : cwdata;
    key = int'(sel) * 65536 + int'(a);
    if (we) m_mem[key] = wd;
    else    m_rd[sel] = m_mem.exists(key) ? m_mem[key] : 32'h0;
    for (int c = 0; c <= lat + 2; c++) begin
      @(negedge clock);
      chk("busy",      o_busy,      c != 0);
      chk("mem_en",    o_mem_en,    c == 1);
      chk("mem_we",    o_mem_we,    (c == 1) && we);
      if (c >= 1 && c <= lat + 1) chk("mem_addr", o_mem_addr, a);
      if (c == 1 && we) chk("mem_wdata", o_mem_wdata, wd);
      chk("cpu_ack",   o_cpu_ack,   (c == lat + 2) && !g);
      chk("ld_ack",    o_ld_ack,    (c == lat + 2) && g);
      chk("cpu_stall", o_cpu_stall, creq && !((c == lat + 2) && !g));
      if (c == lat + 2) chk("rdata", g ? o_ld_rdata : o_cpu_rdata, m_rd[sel]);
      if (wiggle && c == 1) begin
        lock  = 1'b1;
        caddr = ~caddr;
        laddr = ~laddr;
      end
      @(posedge clock);
      #1;
    end
    if (g) lreq = 1'b0;
    else   creq = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    chk_idle("rst");
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    m_mem[65536 + 'h155] = 32'h1234_5678;
    #2 reset = 1'b0;
    @(posedge clock);
    #1;
    clr   = 1'b0;
    pl_en = 1'b0;
    chk_idle("por");
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;

    // CPU write then read back.
    creq = 1; cwe = 1; caddr = 14'h010; cwdata = 32'hDEAD_BEEF;
    txn(0);
    creq = 1; cwe = 0; caddr = 14'h010;
    txn(0);

    // Locked CPU alone: nothing granted, CPU stalls.
    creq = 1; lock = 1; lreq = 0;
    repeat (3) begin
      @(negedge clock);
      chk("lock_busy",  o_busy, 0);
      chk("lock_en",    o_mem_en, 0);
      chk("lock_stall", o_cpu_stall, 1);
      @(posedge clock);
      #1;
    end
    creq = 0; lock = 0;

    // Tie right after reset goes to the CPU, then strict alternation.
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      creq = 1; lreq = 1;
      cwe = 1'($urandom); lwe = 1'($urandom);
      caddr = 14'($urandom_range(0, 7)); laddr = 14'($urandom_range(0, 7));
      cwdata = $urandom; lwdata = $urandom;
      txn(0);
    end

    // Programming mode: loader only, then CPU wins once the lock drops.
    for (int i = 0; i < 5; i++) begin
      creq = 1; lreq = 1; lock = 1;
      lwe = 1'($urandom); laddr = 14'($urandom_range(0, 7)); lwdata = $urandom;
      txn(0);
    end
    lock = 0; lreq = 1; lwe = 0; cwe = 0; caddr = 14'h010;
    txn(0);
    lreq = 0;

    // Lock and address changes mid-access do not disturb a granted CPU read.
    creq = 1; cwe = 0; caddr = 14'h010; lock = 0;
    txn(1);
    lock = 0;

    // Reset during WAIT of a loader write; the write reruns after release.
    creq = 0; lreq = 1; lwe = 1; laddr = 14'h3FF; lwdata = $urandom;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk_idle("rst_wait");
    model_reset();
    repeat (2) begin
      @(negedge clock);
      chk("rst_no_lack", o_ld_ack, 0);
      @(posedge clock);
    end
    #1;
    reset = 1'b1;
    txn(0);

    // Random traffic on the RD_LAT=1 instance.
    for (int i = 0; i < 40; i++) begin
      creq = 1'($urandom); lreq = 1'($urandom); lock = 1'($urandom);
      if (!(creq && !lock) && !lreq) lreq = 1;
      cwe = 1'($urandom); lwe = 1'($urandom);
      caddr = 14'($urandom_range(0, 7)); laddr = 14'($urandom_range(0, 7));
      cwdata = $urandom; lwdata = $urandom;
      txn(0);
    end
    creq = 0; lreq = 0; lock = 0;

    // RD_LAT=4 instance: preloaded loader read, then random traffic.
    sel = 1'b1;
    lreq = 1; lwe = 0; laddr = 14'h155;
    txn(0);
    chk("lat4_rdata", o_ld_rdata, 32'h1234_5678);
    for (int i = 0; i < 10; i++) begin
      creq = 1'($urandom); lreq = 1'($urandom); lock = 0;
      if (!creq && !lreq) creq = 1;
      cwe = 1'($urandom); lwe = 1'($urandom);
      caddr = 14'($urandom_range(0, 7)); laddr = 14'($urandom_range(0, 7));
      cwdata = $urandom; lwdata = $urandom;
      txn(0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
